// File: rtl/uartprobe_ctrl_pkg.sv
// Shared constants for the uartprobe command sequencer: opcodes, status codes,
// FSM state encodings and the per-opcode argument count.
package uartprobe_ctrl_pkg;

  localparam logic [7:0] OP_WR     = 8'h01;
  localparam logic [7:0] OP_RD     = 8'h02;
  localparam logic [7:0] OP_SETGPO = 8'h03;
  localparam logic [7:0] OP_GETGPI = 8'h04;

  localparam logic [7:0] STS_OK    = 8'h00;
  localparam logic [7:0] STS_ERR   = 8'h80;
  localparam logic [7:0] STS_BADOP = 8'hFF;

  localparam logic [2:0] AXI_SIZE_32 = 3'b010;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RX_ARGS  = 3'd1;
  localparam logic [2:0] ST_AXI_AW_W = 3'd2;
  localparam logic [2:0] ST_AXI_B    = 3'd3;
  localparam logic [2:0] ST_AXI_AR   = 3'd4;
  localparam logic [2:0] ST_AXI_R    = 3'd5;
  localparam logic [2:0] ST_EXEC     = 3'd6;
  localparam logic [2:0] ST_TX_RESP  = 3'd7;

  // Argument bytes that follow each opcode; unknown opcodes take none.
  function automatic logic [3:0] arg_count(input logic [7:0] op);
    case (op)
      OP_WR:             return 4'd8;
      OP_RD, OP_SETGPO:  return 4'd4;
      default:           return 4'd0;
    endcase
  endfunction

  // Status byte for an AXI response code: OKAY maps to 0x00, anything else to 0x80|resp.
  function automatic logic [7:0] status_byte(input logic [1:0] resp);
    return (resp == 2'b00) ? STS_OK : (STS_ERR | {6'b0, resp});
  endfunction

endpackage

// File: rtl/uartprobe_ctrl_if.sv
// Bundle of the sequencer's external streams: UART rx/tx bytes, GPO/GPI and the
// single-beat AXI master channels. master = sequencer side, slave = environment side.
interface uartprobe_ctrl_if #(
  parameter int GPO_W = 32,
  parameter int GPI_W = 32
);
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready;
  logic [GPO_W-1:0] gpo;
  logic [GPI_W-1:0] gpi;

  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awsize;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arsize;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  modport master (
    input  rx_valid, rx_data, tx_ready, gpi,
           m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output rx_ready, tx_valid, tx_data, gpo,
           m_axi_awaddr, m_axi_awsize, m_axi_awvalid,
           m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
           m_axi_araddr, m_axi_arsize, m_axi_arvalid, m_axi_rready
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, gpi,
           m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  rx_ready, tx_valid, tx_data, gpo,
           m_axi_awaddr, m_axi_awsize, m_axi_awvalid,
           m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
           m_axi_araddr, m_axi_arsize, m_axi_arvalid, m_axi_rready
  );
endinterface

// File: rtl/uartprobe_ctrl_respser.sv
// Response serialiser: loads a 1- or 5-byte response (first byte in i_data[39:32])
// and streams it MSB-first on the tx byte stream. o_done flags the last handshake.
module uartprobe_ctrl_respser (
  input  logic        clk,
  input  logic        areset,
  input  logic        i_load,
  input  logic        i_len5,
  input  logic [39:0] i_data,
  input  logic        i_tx_ready,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_done
);
  logic [39:0] r_buf;
  logic [2:0]  r_left;
  logic        r_valid;

  // Load a fresh response, otherwise shift one byte out per accepted transfer.
  always_ff @(posedge clk) begin
    if (areset) begin
      r_buf   <= '0;
      r_left  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_buf   <= i_data;
      r_left  <= i_len5 ? 3'd5 : 3'd1;
      r_valid <= 1'b1;
    end else if (r_valid && i_tx_ready) begin
      r_buf  <= {r_buf[31:0], 8'h00};
      r_left <= r_left - 3'd1;
      if (r_left == 3'd1) r_valid <= 1'b0;
    end
  end

  assign o_tx_valid = r_valid;
  assign o_tx_data  = r_buf[39:32];
  assign o_done     = r_valid && i_tx_ready && (r_left == 3'd1);
endmodule

// File: rtl/uartprobe_ctrl.sv
// Command sequencer: parses opcode+argument frames from the UART rx stream, runs one
// single-beat AXI write/read or a GPO/GPI access, and returns a status/data response.
module uartprobe_ctrl
  import uartprobe_ctrl_pkg::*;
#(
  parameter int          UAP_GPO_W  = 32,
  parameter int          UAP_GPI_W  = 32,
  parameter logic [31:0] GPO_RESET  = 32'h0,
  parameter int          RX_TIMEOUT = 1000000
) (
  input logic              clk,
  input logic              areset,
  uartprobe_ctrl_if.master bus
);
  localparam int               CNT_W      = $clog2(RX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(RX_TIMEOUT - 1);

  logic [2:0]           r_state;
  logic [7:0]           r_opcode;
  logic [3:0]           r_arg_cnt;
  logic [63:0]          r_args;
  logic [CNT_W-1:0]     r_idle_cnt;
  logic                 r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [31:0]          r_awaddr, r_wdata, r_araddr;
  logic [UAP_GPO_W-1:0] r_gpo;

  logic                 w_rx_ready, w_rx_fire;
  logic [63:0]          w_args_next;
  logic                 w_aw_pend, w_w_pend;
  logic                 w_load, w_load_len5, w_tx_done;
  logic [39:0]          w_load_data;
  logic [UAP_GPI_W-1:0] w_gpi;

  assign w_gpi       = bus.gpi;
  assign w_rx_ready  = !areset && (r_state == ST_IDLE || r_state == ST_RX_ARGS);
  assign w_rx_fire   = bus.rx_valid && w_rx_ready;
  assign w_args_next = {r_args[55:0], bus.rx_data};
  assign w_aw_pend   = r_awvalid && !bus.m_axi_awready;
  assign w_w_pend    = r_wvalid && !bus.m_axi_wready;

  // The response is loaded on the edge where the result becomes known.
  assign w_load      = (r_state == ST_EXEC)
                    || (r_state == ST_AXI_B && bus.m_axi_bvalid)
                    || (r_state == ST_AXI_R && bus.m_axi_rvalid);
  assign w_load_len5 = (r_state == ST_AXI_R)
                    || (r_state == ST_EXEC && r_opcode == OP_GETGPI);

  // Select the response contents for whichever result is completing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_load_data = {STS_BADOP, 32'h0};
    if (r_state == ST_AXI_B)
      w_load_data = {status_byte(bus.m_axi_bresp), 32'h0};
    else if (r_state == ST_AXI_R)
      w_load_data = {status_byte(bus.m_axi_rresp), bus.m_axi_rdata};
    else if (r_opcode == OP_GETGPI)
      w_load_data = {STS_OK, 32'(w_gpi)};
    else if (r_opcode == OP_SETGPO)
      w_load_data = {STS_OK, 32'h0};
  end

  // Frame parsing, AXI handshakes and GPO update; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (areset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      r_state    <= ST_IDLE;
      r_opcode   <= '0;
      r_arg_cnt  <= '0;
      r_args     <= '0;
      r_idle_cnt <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_araddr   <= '0;
      r_gpo      <= GPO_RESET[UAP_GPO_W-1:0];
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rx_fire) begin
            r_opcode   <= bus.rx_data;
            r_idle_cnt <= '0;
            r_arg_cnt  <= arg_count(bus.rx_data);
            r_state    <= (arg_count(bus.rx_data) == 4'd0) ? ST_EXEC : ST_RX_ARGS;
          end
        end
        ST_RX_ARGS: begin
          if (w_rx_fire) begin
            r_args     <= w_args_next;
            r_idle_cnt <= '0;
            r_arg_cnt  <= r_arg_cnt - 4'd1;
            if (r_arg_cnt == 4'd1) begin
              case (r_opcode)
                OP_WR: begin
                  r_awaddr  <= w_args_next[63:32];
                  r_wdata   <= w_args_next[31:0];
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
                  r_state   <= ST_AXI_AW_W;
                end
                OP_RD: begin
                  r_araddr  <= w_args_next[31:0];
                  r_arvalid <= 1'b1;
                  r_state   <= ST_AXI_AR;
                end
                default: begin
                  r_gpo   <= w_args_next[UAP_GPO_W-1:0];
                  r_state <= ST_EXEC;
                end
              endcase
            end
          end else if (r_idle_cnt == IDLE_LIMIT) begin
            // Stalled frame: drop it silently.
            r_idle_cnt <= '0;
            r_arg_cnt  <= '0;
            r_state    <= ST_IDLE;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        ST_AXI_AW_W: begin
          if (bus.m_axi_awready) r_awvalid <= 1'b0;
          if (bus.m_axi_wready)  r_wvalid  <= 1'b0;
          if (!w_aw_pend && !w_w_pend) begin
            r_bready <= 1'b1;
            r_state  <= ST_AXI_B;
          end
        end
        ST_AXI_B: begin
          if (bus.m_axi_bvalid) begin
            r_bready <= 1'b0;
            r_state  <= ST_TX_RESP;
          end
        end
        ST_AXI_AR: begin
          if (bus.m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_AXI_R;
          end
        end
        ST_AXI_R: begin
          if (bus.m_axi_rvalid) begin
            r_rready <= 1'b0;
            r_state  <= ST_TX_RESP;
          end
        end
        ST_EXEC:    r_state <= ST_TX_RESP;
        ST_TX_RESP: if (w_tx_done) r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  uartprobe_ctrl_respser u_respser (
    .clk        (clk),
    .areset     (areset),
    .i_load     (w_load),
    .i_len5     (w_load_len5),
    .i_data     (w_load_data),
    .i_tx_ready (bus.tx_ready),
    .o_tx_valid (bus.tx_valid),
    .o_tx_data  (bus.tx_data),
    .o_done     (w_tx_done)
  );

  assign bus.rx_ready      = w_rx_ready;
  assign bus.gpo           = r_gpo;
  assign bus.m_axi_awaddr  = r_awaddr;
  assign bus.m_axi_awsize  = AXI_SIZE_32;
  assign bus.m_axi_awvalid = r_awvalid;
  assign bus.m_axi_wdata   = r_wdata;
  assign bus.m_axi_wstrb   = 4'hF;
  assign bus.m_axi_wlast   = 1'b1;
  assign bus.m_axi_wvalid  = r_wvalid;
  assign bus.m_axi_bready  = r_bready;
  assign bus.m_axi_araddr  = r_araddr;
  assign bus.m_axi_arsize  = AXI_SIZE_32;
  assign bus.m_axi_arvalid = r_arvalid;
  assign bus.m_axi_rready  = r_rready;
endmodule

// File: tb/tb_uartprobe_ctrl.sv
// Bench for uartprobe_ctrl: directed scenarios followed by random frames, each
// response compared against a frame-level model of the command protocol.
module tb_uartprobe_ctrl;
  localparam int          TIMEOUT = 40;
  localparam logic [31:0] GPO_RST = 32'h0000_1234;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  uartprobe_ctrl_if #(.GPO_W(32), .GPI_W(32)) bus ();

  uartprobe_ctrl #(
    .UAP_GPO_W (32),
    .UAP_GPI_W (32),
    .GPO_RESET (GPO_RST),
    .RX_TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .areset(areset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Slave behaviour knobs
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  b_resp_cfg = 2'd0, r_resp_cfg = 2'd0;
  logic [31:0] r_data_cfg = 32'h0;

  // Handshake monitor
  int aw_hs = 0, w_hs = 0, ar_hs = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [2:0]  cap_awsize = '0, cap_arsize = '0;
  logic [3:0]  cap_wstrb = '0;
  logic        cap_wlast = 1'b0;

  logic [7:0] frame_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (bus.m_axi_awvalid && bus.m_axi_awready) begin
      aw_hs      <= aw_hs + 1;
      cap_awaddr <= bus.m_axi_awaddr;
      cap_awsize <= bus.m_axi_awsize;
    end
    if (bus.m_axi_wvalid && bus.m_axi_wready) begin
      w_hs      <= w_hs + 1;
      cap_wdata <= bus.m_axi_wdata;
      cap_wstrb <= bus.m_axi_wstrb;
      cap_wlast <= bus.m_axi_wlast;
    end
    if (bus.m_axi_arvalid && bus.m_axi_arready) begin
      ar_hs      <= ar_hs + 1;
      cap_araddr <= bus.m_axi_araddr;
      cap_arsize <= bus.m_axi_arsize;
    end
  end

  // AXI slave responders: each ready/valid pulses for one cycle after its delay.
  initial begin
    int aw_wait = 0;
    bus.m_axi_awready = 1'b0;
    forever begin
      @(negedge clk);
      bus.m_axi_awready = 1'b0;
      if (bus.m_axi_awvalid) begin
        if (aw_wait >= aw_dly) begin bus.m_axi_awready = 1'b1; aw_wait = 0; end
        else aw_wait++;
      end else aw_wait = 0;
    end
  end

  initial begin
    int w_wait = 0;
    bus.m_axi_wready = 1'b0;
    forever begin
      @(negedge clk);
      bus.m_axi_wready = 1'b0;
      if (bus.m_axi_wvalid) begin
        if (w_wait >= w_dly) begin bus.m_axi_wready = 1'b1; w_wait = 0; end
        else w_wait++;
      end else w_wait = 0;
    end
  end

  initial begin
    int b_wait = 0;
    bus.m_axi_bvalid = 1'b0;
    bus.m_axi_bresp  = 2'd0;
    forever begin
      @(negedge clk);
      bus.m_axi_bvalid = 1'b0;
      if (bus.m_axi_bready) begin
        if (b_wait >= b_dly) begin
          bus.m_axi_bvalid = 1'b1;
          bus.m_axi_bresp  = b_resp_cfg;
          b_wait = 0;
        end else b_wait++;
      end else b_wait = 0;
    end
  end

  initial begin
    int ar_wait = 0;
    bus.m_axi_arready = 1'b0;
    forever begin
      @(negedge clk);
      bus.m_axi_arready = 1'b0;
      if (bus.m_axi_arvalid) begin
        if (ar_wait >= ar_dly) begin bus.m_axi_arready = 1'b1; ar_wait = 0; end
        else ar_wait++;
      end else ar_wait = 0;
    end
  end

  initial begin
    int r_wait = 0;
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rdata  = 32'h0;
    bus.m_axi_rresp  = 2'd0;
    bus.m_axi_rlast  = 1'b0;
    forever begin
      @(negedge clk);
      bus.m_axi_rvalid = 1'b0;
      bus.m_axi_rlast  = 1'b0;
      if (bus.m_axi_rready) begin
        if (r_wait >= r_dly) begin
          bus.m_axi_rvalid = 1'b1;
          bus.m_axi_rlast  = 1'b1;
          bus.m_axi_rdata  = r_data_cfg;
          bus.m_axi_rresp  = r_resp_cfg;
          r_wait = 0;
        end else r_wait++;
      end else r_wait = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model helpers ----------------
  function automatic logic [7:0] model_status(input int resp);
    if (resp == 0) return 8'h00;
    return 8'(128 + resp);
  endfunction

  task automatic push_word(inout logic [7:0] q[$], input logic [31:0] x);
    for (int s = 24; s >= 0; s -= 8) q.push_back(8'((x >> s) & 32'hFF));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && t < 200) begin @(negedge clk); t++; end
    check("rx_accept_in_time", 40'(t < 200), 40'h1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i > 0 && max_gap > 0) repeat ($urandom % (max_gap + 1)) @(negedge clk);
      send_byte(frame_q[i]);
    end
  endtask

  task automatic collect(input int n, input bit toggle);
    int cyc = 0;
    got_q.delete();
    while (got_q.size() < n && cyc < 400) begin
      bus.tx_ready = toggle ? cyc[0] : 1'b1;
      if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
      @(negedge clk);
      cyc++;
    end
    bus.tx_ready = 1'b0;
  endtask

  task automatic check_resp(input string tag);
    check({tag, "_len"}, 40'(got_q.size()), 40'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i),
            (i < got_q.size()) ? 40'(got_q[i]) : 40'hx, 40'(exp_q[i]));
    check({tag, "_no_extra"}, 40'(bus.tx_valid), 40'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 40'(bus.rx_ready),      40'h0);
    check({tag, "_tx_valid"}, 40'(bus.tx_valid),      40'h0);
    check({tag, "_tx_data"},  40'(bus.tx_data),       40'h0);
    check({tag, "_awvalid"},  40'(bus.m_axi_awvalid), 40'h0);
    check({tag, "_wvalid"},   40'(bus.m_axi_wvalid),  40'h0);
    check({tag, "_bready"},   40'(bus.m_axi_bready),  40'h0);
    check({tag, "_arvalid"},  40'(bus.m_axi_arvalid), 40'h0);
    check({tag, "_rready"},   40'(bus.m_axi_rready),  40'h0);
    check({tag, "_awaddr"},   40'(bus.m_axi_awaddr),  40'h0);
    check({tag, "_wdata"},    40'(bus.m_axi_wdata),   40'h0);
    check({tag, "_araddr"},   40'(bus.m_axi_araddr),  40'h0);
    check({tag, "_gpo"},      40'(bus.gpo),           40'(GPO_RST));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int t;
    int kind;
    int aw0, w0, ar0;
    logic [31:0] a, d, g;
    logic [31:0] model_gpo;
    logic [7:0]  op;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;
    bus.gpi      = 32'h0;
    model_gpo    = GPO_RST;

    // Reset, then idle
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    areset = 1'b0;
    @(negedge clk);
    check("idle_rx_ready", 40'(bus.rx_ready), 40'h1);
    check("idle_gpo", 40'(bus.gpo), 40'(GPO_RST));

    // WR 0x1000 <= 0xDEADBEEF, awready three cycles ahead of wready
    aw_dly = 0; w_dly = 3; b_dly = 1; b_resp_cfg = 2'd0;
    aw0 = aw_hs; w0 = w_hs;
    frame_q = '{8'h01};
    push_word(frame_q, 32'h0000_1000);
    push_word(frame_q, 32'hDEAD_BEEF);
    send_frame(0);
    check("wr_awvalid_latency", 40'(bus.m_axi_awvalid), 40'h1);
    check("wr_wvalid_latency",  40'(bus.m_axi_wvalid),  40'h1);
    exp_q = '{model_status(0)};
    collect(1, 1'b0);
    check_resp("wr");
    check("wr_aw_count", 40'(aw_hs - aw0), 40'h1);
    check("wr_w_count",  40'(w_hs - w0),   40'h1);
    check("wr_awaddr", 40'(cap_awaddr), 40'h1000);
    check("wr_wdata",  40'(cap_wdata),  40'hDEADBEEF);
    check("wr_awsize", 40'(cap_awsize), 40'h2);
    check("wr_wstrb",  40'(cap_wstrb),  40'hF);
    check("wr_wlast",  40'(cap_wlast),  40'h1);

    // RD 0x2000 with SLVERR, tx_ready toggling
    ar_dly = 1; r_dly = 2; r_resp_cfg = 2'd2; r_data_cfg = 32'h1234_5678;
    frame_q = '{8'h02};
    push_word(frame_q, 32'h0000_2000);
    send_frame(0);
    exp_q = '{model_status(2)};
    push_word(exp_q, 32'h1234_5678);
    collect(5, 1'b1);
    check_resp("rd");
    check("rd_araddr", 40'(cap_araddr), 40'h2000);
    check("rd_arsize", 40'(cap_arsize), 40'h2);

    // SETGPO then GETGPI
    frame_q = '{8'h03};
    push_word(frame_q, 32'hA5A5_A5A5);
    send_frame(0);
    model_gpo = 32'hA5A5_A5A5;
    check("setgpo_gpo_timing", 40'(bus.gpo), 40'(model_gpo));
    exp_q = '{8'h00};
    collect(1, 1'b0);
    check_resp("setgpo");

    bus.gpi = 32'h0F0F_0F0F;
    frame_q = '{8'h04};
    send_frame(0);
    check("getgpi_tx_early", 40'(bus.tx_valid), 40'h0);
    @(negedge clk);
    check("getgpi_tx_latency", 40'(bus.tx_valid), 40'h1);
    exp_q = '{8'h00};
    push_word(exp_q, 32'h0F0F_0F0F);
    collect(5, 1'b0);
    check_resp("getgpi");
    check("getgpi_gpo_kept", 40'(bus.gpo), 40'(model_gpo));

    // Unknown opcode
    frame_q = '{8'h7E};
    send_frame(0);
    exp_q = '{8'hFF};
    collect(1, 1'b0);
    check_resp("badop");

    // Stalled WR frame is dropped, next WR is handled normally
    aw0 = aw_hs;
    frame_q = '{8'h01, 8'h11, 8'h22};
    send_frame(0);
    bus.tx_ready = 1'b1;
    repeat (TIMEOUT + 10) @(negedge clk);
    bus.tx_ready = 1'b0;
    check("stall_no_aw", 40'(aw_hs - aw0), 40'h0);
    check("stall_awvalid", 40'(bus.m_axi_awvalid), 40'h0);
    check("stall_no_tx", 40'(bus.tx_valid), 40'h0);
    aw_dly = 2; w_dly = 0; b_dly = 0; b_resp_cfg = 2'd0;
    frame_q = '{8'h01};
    push_word(frame_q, 32'hCAFE_0004);
    push_word(frame_q, 32'h0BAD_F00D);
    send_frame(0);
    exp_q = '{8'h00};
    collect(1, 1'b0);
    check_resp("post_stall_wr");
    check("post_stall_awaddr", 40'(cap_awaddr), 40'hCAFE0004);
    check("post_stall_wdata",  40'(cap_wdata),  40'h0BADF00D);

    // Reset while waiting for BVALID
    b_dly = 1000;
    frame_q = '{8'h01};
    push_word(frame_q, 32'h0000_3000);
    push_word(frame_q, 32'h5555_AAAA);
    send_frame(0);
    t = 0;
    while (!bus.m_axi_bready && t < 50) begin @(negedge clk); t++; end
    check("reached_axi_b", 40'(bus.m_axi_bready), 40'h1);
    areset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    b_dly = 0;
    areset = 1'b0;
    model_gpo = GPO_RST;
    @(negedge clk);
    r_resp_cfg = 2'd0; r_data_cfg = 32'h8765_4321;
    frame_q = '{8'h02};
    push_word(frame_q, 32'h0000_4000);
    send_frame(0);
    exp_q = '{8'h00};
    push_word(exp_q, 32'h8765_4321);
    collect(5, 1'b0);
    check_resp("rd_after_reset");
    check("rd_after_reset_araddr", 40'(cap_araddr), 40'h4000);

    // Random frames against the protocol model
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 4));
      a = $urandom();
      d = $urandom();
      aw_dly = int'($urandom_range(0, 3)); w_dly = int'($urandom_range(0, 3));
      b_dly  = int'($urandom_range(0, 3)); ar_dly = int'($urandom_range(0, 3));
      r_dly  = int'($urandom_range(0, 3));
      b_resp_cfg = 2'($urandom_range(0, 3));
      r_resp_cfg = 2'($urandom_range(0, 3));
      r_data_cfg = $urandom();
      aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs;
      frame_q.delete();
      exp_q.delete();
      case (kind)
        0: begin
          frame_q.push_back(8'h01);
          push_word(frame_q, a);
          push_word(frame_q, d);
          exp_q.push_back(model_status(int'(b_resp_cfg)));
        end
        1: begin
          frame_q.push_back(8'h02);
          push_word(frame_q, a);
          exp_q.push_back(model_status(int'(r_resp_cfg)));
          push_word(exp_q, r_data_cfg);
        end
        2: begin
          frame_q.push_back(8'h03);
          push_word(frame_q, d);
          exp_q.push_back(8'h00);
          model_gpo = d;
        end
        3: begin
          g = $urandom();
          bus.gpi = g;
          frame_q.push_back(8'h04);
          exp_q.push_back(8'h00);
          push_word(exp_q, g);
        end
        default: begin
          op = 8'($urandom_range(5, 255));
          frame_q.push_back(op);
          exp_q.push_back(8'hFF);
        end
      endcase
      send_frame(3);
      collect(exp_q.size(), it[0]);
      check_resp($sformatf("rand%0d_k%0d", it, kind));
      check($sformatf("rand%0d_gpo", it), 40'(bus.gpo), 40'(model_gpo));
      if (kind == 0) begin
        check($sformatf("rand%0d_aw_count", it), 40'(aw_hs - aw0), 40'h1);
        check($sformatf("rand%0d_w_count", it),  40'(w_hs - w0),   40'h1);
        check($sformatf("rand%0d_awaddr", it), 40'(cap_awaddr), 40'(a));
        check($sformatf("rand%0d_wdata", it),  40'(cap_wdata),  40'(d));
      end else if (kind == 1) begin
        check($sformatf("rand%0d_ar_count", it), 40'(ar_hs - ar0), 40'h1);
        check($sformatf("rand%0d_araddr", it), 40'(cap_araddr), 40'(a));
      end else begin
        check($sformatf("rand%0d_no_axi", it), 40'((aw_hs - aw0) + (ar_hs - ar0)), 40'h0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
